parse_encode: RTL and testbench
===============================

PARSE_ENCODE -- requirements
Module: parse_encode

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 The module SHALL have port in_valid, input, 1 bit: in_char is valid this cycle.
REQ-004 The module SHALL have port in_char, input, 8 bits: ASCII character of the command stream.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the module accepts in_char this cycle.
REQ-006 The module SHALL have port out_valid, output, 1 bit: out_instr and out_err are valid.
REQ-007 The module SHALL have port out_instr, output, 32 bits: encoded MIPS instruction word.
REQ-008 The module SHALL have port out_err, output, 2 bits: 0 = ok, 1 = bad hex character, 2 = unknown type code, 3 = frame too long.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-010 Frame format SHALL be: 2 type chars T, 8 hex operand chars P[31:0] (most significant first), then CR (8'h0D).
REQ-011 Hex digits SHALL be 0-9, A-F and a-f.
REQ-012 A char SHALL be consumed only when in_valid and in_ready are both high.
REQ-013 in_ready SHALL be high in states TYPE, OPER, WAIT_CR and FLUSH, and low in EMIT.
REQ-014 State TYPE SHALL collect 2 chars, using char counter values 0-1.
REQ-015 The type chars "xx" or "XX" SHALL mark a bubble.
REQ-016 Any other type chars SHALL be hex digits; otherwise the module SHALL latch err=1 and go to FLUSH.
REQ-017 State OPER SHALL collect 8 hex digits; a non-hex digit SHALL latch err=1 and go to FLUSH.
REQ-018 In state WAIT_CR, a CR SHALL go to EMIT; any other char SHALL latch err=3 and go to FLUSH.
REQ-019 State FLUSH SHALL discard chars until CR, then go to EMIT carrying the latched error.
REQ-020 A CR received in TYPE or OPER before the frame is complete SHALL give err=1 and go straight to EMIT.
REQ-021 In EMIT, out_valid SHALL be high; the result SHALL be held stable until out_valid and out_ready are both high; the module SHALL then return to TYPE the next cycle.
REQ-022 Latency SHALL be 1 cycle: out_valid rises the cycle after the CR handshake.
REQ-023 Type-to-opcode map (T hex -> mnemonic):
  - 01 ADD, 02 SUB, 03 AND, 04 OR, 05 SLL, 06 SRL, 07 SRA
  - 08 ADDI, 09 ANDI, 0A ORI, 0B LW, 0C SW, 0D BEQ, 0E BNE, 0F JMP
  - 10 ADDU, 11 SUBU, 12 XOR, 13 NOR, 14 SLT, 15 SLTU, 16 SLLV, 17 SRLV, 18 SRAV, 19 JR
  - 1A ADDIU, 1B XORI, 1C LUI, 1D SLTI, 1E SLTIU, 1F JAL
REQ-024 R-class types (01-07, 10-19) SHALL encode out_instr = {`R, P[25:6], func}.
REQ-025 All other mapped types SHALL encode out_instr = {op, P[25:0]}.
REQ-026 P[31:26] SHALL be ignored for every type.
REQ-027 An unmapped T (00, 20-FF) SHALL give err=2.
REQ-028 A bubble SHALL output 32'h00000000 with err=0, whatever P holds.
REQ-029 When out_err is nonzero, out_instr SHALL be 32'h00000000.
REQ-030 When both a CR and an error occur on one char, the first error latched in the frame SHALL be reported.

Reset
REQ-031 While rst_n is low at a clock edge: state = TYPE, counter = 0, out_valid = 0, out_instr = 0, out_err = 0, in_ready = 1.
REQ-032 Reset asserted mid-frame or during EMIT SHALL drop the partial frame or pending result without emitting it.

Structure
REQ-033 Opcode/func constants (`R, `ADD ... `JAL) and the type-code values SHALL live in the shared header.v.
REQ-034 State encodings SHALL live in the shared header.v.
REQ-035 One sub-module asc2bin SHALL map an ASCII char to {is_hex, nibble[3:0]}.
REQ-036 asc2bin SHALL be the inverse of the display-side bin2asc and be instantiated once on in_char.

Verification
REQ-037 Stream "01","00221800",CR -> out_instr 32'h00221820, err 0, out_valid 1 cycle after the CR.
REQ-038 Stream "0b","00410004",CR -> 32'h8C410004, err 0.
REQ-039 Stream "2A","00000000",CR -> out_instr 0, err 2; stream "xx","FFFFFFFF",CR -> out_instr 0, err 0.
REQ-040 Stream "08","00G1",...,CR -> err 1 at CR; chars between 'G' and CR consumed; next frame "0F","00000010",CR -> 32'h08000010.
REQ-041 out_ready held low for 5 cycles in EMIT -> out_instr stable, in_ready low; one extra char sent before CR -> err 3.
REQ-042 rst_n pulsed low after 5 operand chars -> no output; a following full frame encodes correctly.

Source files
------------

// File: rtl/parse_encode_pkg.sv
// Shared definitions for the ASCII command-stream to MIPS instruction encoder:
// FSM state encodings, error codes, type codes, opcode/func fields and the
// type-to-instruction encode function.
package parse_encode_pkg;

  typedef enum logic [2:0] {
    S_TYPE    = 3'd0,
    S_OPER    = 3'd1,
    S_WAIT_CR = 3'd2,
    S_FLUSH   = 3'd3,
    S_EMIT    = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_HEX  = 2'd1;
  localparam logic [1:0] ERR_TYPE = 2'd2;
  localparam logic [1:0] ERR_LONG = 2'd3;

  // Type codes carried in the two leading hex characters of a frame
  localparam logic [7:0] T_ADD  = 8'h01, T_SUB  = 8'h02, T_AND   = 8'h03, T_OR   = 8'h04;
  localparam logic [7:0] T_SLL  = 8'h05, T_SRL  = 8'h06, T_SRA   = 8'h07, T_ADDI = 8'h08;
  localparam logic [7:0] T_ANDI = 8'h09, T_ORI  = 8'h0A, T_LW    = 8'h0B, T_SW   = 8'h0C;
  localparam logic [7:0] T_BEQ  = 8'h0D, T_BNE  = 8'h0E, T_JMP   = 8'h0F, T_ADDU = 8'h10;
  localparam logic [7:0] T_SUBU = 8'h11, T_XOR  = 8'h12, T_NOR   = 8'h13, T_SLT  = 8'h14;
  localparam logic [7:0] T_SLTU = 8'h15, T_SLLV = 8'h16, T_SRLV  = 8'h17, T_SRAV = 8'h18;
  localparam logic [7:0] T_JR   = 8'h19, T_ADDIU= 8'h1A, T_XORI  = 8'h1B, T_LUI  = 8'h1C;
  localparam logic [7:0] T_SLTI = 8'h1D, T_SLTIU= 8'h1E, T_JAL   = 8'h1F;

  // Opcode field values
  localparam logic [5:0] OP_R    = 6'h00, OP_JMP  = 6'h02, OP_JAL  = 6'h03, OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05, OP_ADDI = 6'h08, OP_ADDIU= 6'h09, OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_SLTIU= 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

  // R-class func field values
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03, FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR   = 6'h08, FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Returns {err, instr}; P[31:26] never reaches the instruction word.
  function automatic logic [33:0] encode(input logic [7:0] t, input logic [31:0] p);
    logic       r_class;
    logic       mapped;
    logic [5:0] code;
    r_class = 1'b0;
    mapped  = 1'b1;
    code    = 6'h00;
    case (t)
      T_ADD:   begin r_class = 1'b1; code = FN_ADD;  end
      T_SUB:   begin r_class = 1'b1; code = FN_SUB;  end
      T_AND:   begin r_class = 1'b1; code = FN_AND;  end
      T_OR:    begin r_class = 1'b1; code = FN_OR;   end
      T_SLL:   begin r_class = 1'b1; code = FN_SLL;  end
      T_SRL:   begin r_class = 1'b1; code = FN_SRL;  end
      T_SRA:   begin r_class = 1'b1; code = FN_SRA;  end
      T_ADDU:  begin r_class = 1'b1; code = FN_ADDU; end
      T_SUBU:  begin r_class = 1'b1; code = FN_SUBU; end
      T_XOR:   begin r_class = 1'b1; code = FN_XOR;  end
      T_NOR:   begin r_class = 1'b1; code = FN_NOR;  end
      T_SLT:   begin r_class = 1'b1; code = FN_SLT;  end
      T_SLTU:  begin r_class = 1'b1; code = FN_SLTU; end
      T_SLLV:  begin r_class = 1'b1; code = FN_SLLV; end
      T_SRLV:  begin r_class = 1'b1; code = FN_SRLV; end
      T_SRAV:  begin r_class = 1'b1; code = FN_SRAV; end
      T_JR:    begin r_class = 1'b1; code = FN_JR;   end
      T_ADDI:  code = OP_ADDI;
      T_ANDI:  code = OP_ANDI;
      T_ORI:   code = OP_ORI;
      T_LW:    code = OP_LW;
      T_SW:    code = OP_SW;
      T_BEQ:   code = OP_BEQ;
      T_BNE:   code = OP_BNE;
      T_JMP:   code = OP_JMP;
      T_ADDIU: code = OP_ADDIU;
      T_XORI:  code = OP_XORI;
      T_LUI:   code = OP_LUI;
      T_SLTI:  code = OP_SLTI;
      T_SLTIU: code = OP_SLTIU;
      T_JAL:   code = OP_JAL;
      default: mapped = 1'b0;
    endcase
    if (!mapped)
      encode = {ERR_TYPE, 32'h0000_0000};
    else if (r_class)
      encode = {ERR_OK, OP_R, p[25:6], code};
    else
      encode = {ERR_OK, code, p[25:0]};
  endfunction

endpackage

// File: rtl/parse_encode_asc2bin.sv
// ASCII to nibble decoder, inverse of the display-side bin2asc.
// Accepts 0-9, A-F and a-f; anything else reports is_hex = 0.
module asc2bin
  import parse_encode_pkg::*;
(
  input  logic [7:0] asc,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Range decode of the three hex character groups
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (asc >= 8'h30 && asc <= 8'h39)
      nibble = asc[3:0];
    else if ((asc >= 8'h41 && asc <= 8'h46) || (asc >= 8'h61 && asc <= 8'h66))
      nibble = asc[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

endmodule

// File: rtl/parse_encode.sv
// Parses framed ASCII commands (2 type chars, 8 hex operand chars, CR) and
// emits the encoded MIPS instruction word with a valid/ready handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   TYPE    | collecting the two type characters (cnt 0-1)
//   OPER    | collecting eight operand hex digits (cnt 0-7)
//   WAIT_CR | frame complete, expecting the terminating CR
//   FLUSH   | error latched, discarding characters until CR
//   EMIT    | result presented, waiting for out_ready
module parse_encode
  import parse_encode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [1:0]  out_err,
  input  logic        out_ready
);

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  first_char;
  logic        first_hex;
  logic        bubble;
  logic [7:0]  type_code;
  logic [31:0] operand;
  logic [1:0]  err_q;

  logic        is_hex;
  logic [3:0]  nib;
  logic        accept;
  logic        is_cr;
  logic        is_x;
  logic [33:0] enc;

  asc2bin u_asc2bin (
    .asc    (in_char),
    .is_hex (is_hex),
    .nibble (nib)
  );

  assign accept = in_valid && in_ready;
  assign is_cr  = (in_char == CHAR_CR);
  assign is_x   = (in_char == 8'h78) || (in_char == 8'h58);
  assign enc    = encode(type_code, operand);

  // Frame parser FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_TYPE;
      cnt        <= 3'd0;
      first_char <= 8'h00;
      first_hex  <= 1'b0;
      bubble     <= 1'b0;
      type_code  <= 8'h00;
      operand    <= 32'h0;
      err_q      <= ERR_OK;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0;
      out_err    <= ERR_OK;
    end else begin
      case (state)
        S_TYPE: if (accept) begin
          if (is_cr) begin
            out_err   <= ERR_HEX;
            out_instr <= 32'h0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_EMIT;
          end else if (cnt == 3'd0) begin
            first_char      <= in_char;
            first_hex       <= is_hex;
            type_code[7:4]  <= nib;
            if (is_hex || is_x) cnt <= 3'd1;
            else begin
              err_q <= ERR_HEX;
              state <= S_FLUSH;
            end
          end else begin
            type_code[3:0] <= nib;
            cnt            <= 3'd0;
            // Bubble only for matching case: "xx" or "XX"
            if (is_x && (in_char == first_char)) begin
              bubble <= 1'b1;
              state  <= S_OPER;
            end else if (is_hex && first_hex) begin
              state <= S_OPER;
            end else begin
              err_q <= ERR_HEX;
              state <= S_FLUSH;
            end
          end
        end
        S_OPER: if (accept) begin
          if (is_cr) begin
            out_err   <= ERR_HEX;
            out_instr <= 32'h0;
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_EMIT;
          end else if (!is_hex) begin
            err_q <= ERR_HEX;
            state <= S_FLUSH;
          end else begin
            operand <= {operand[27:0], nib};
            if (cnt == 3'd7) begin
              cnt   <= 3'd0;
              state <= S_WAIT_CR;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_WAIT_CR: if (accept) begin
          if (is_cr) begin
            out_err   <= bubble ? ERR_OK : enc[33:32];
            out_instr <= bubble ? 32'h0 : enc[31:0];
            out_valid <= 1'b1;
            in_ready  <= 1'b0;
            state     <= S_EMIT;
          end else begin
            err_q <= ERR_LONG;
            state <= S_FLUSH;
          end
        end
        S_FLUSH: if (accept && is_cr) begin
          out_err   <= err_q;
          out_instr <= 32'h0;
          out_valid <= 1'b1;
          in_ready  <= 1'b0;
          state     <= S_EMIT;
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          cnt       <= 3'd0;
          bubble    <= 1'b0;
          err_q     <= ERR_OK;
          state     <= S_TYPE;
        end
        default: state <= S_TYPE;
      endcase
    end
  end

endmodule

// File: tb/tb_parse_encode.sv
// Directed bench for parse_encode: frames are sent one char per handshake,
// inputs are driven and outputs sampled on the falling clock edge.
module tb_parse_encode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [1:0]  out_err;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;

  parse_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_err   (out_err),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Offer one char; returns at the falling edge after it was consumed.
  task automatic send_char(input logic [7:0] c);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!in_ready) begin
      fails++;
      $display("FAIL send_char_timeout: in_ready=%0b required=1 char=%02h", in_ready, c);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  // Samples the presented result, then completes the output handshake.
  task automatic pop_result(output logic v, output logic [31:0] ins, output logic [1:0] e);
    v   = out_valid;
    ins = out_instr;
    e   = out_err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_out_instr: got %08h want 00000000", out_instr); end
    if (out_err !== 2'd0) begin fails++; $display("FAIL reset_out_err: got %0d want 0", out_err); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rtype;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("0100221800");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 4;
    if (v !== 1'b1) begin fails++; $display("FAIL rtype_latency: out_valid got %0b want 1", v); end
    if (ins !== 32'h00221820) begin fails++; $display("FAIL rtype_instr: got %08h want 00221820", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL rtype_err: got %0d want 0", e); end
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rtype_release: out_valid got %0b want 0", out_valid); end
    send_str("10FFFFFFFF");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (ins !== 32'h03FFFFE1) begin fails++; $display("FAIL addu_top_ignored: got %08h want 03FFFFE1", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL addu_err: got %0d want 0", e); end
  endtask

  task automatic test_itype;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("0b00410004");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (ins !== 32'h8C410004) begin fails++; $display("FAIL lw_instr: got %08h want 8C410004", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL lw_err: got %0d want 0", e); end
    send_str("1CFC00ABCD");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks++;
    if (ins !== 32'h3C00ABCD) begin fails++; $display("FAIL lui_top_ignored: got %08h want 3C00ABCD", ins); end
  endtask

  task automatic test_unmapped_bubble;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("2A00000000");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 3;
    if (v !== 1'b1) begin fails++; $display("FAIL unmapped_valid: got %0b want 1", v); end
    if (ins !== 32'h0) begin fails++; $display("FAIL unmapped_instr: got %08h want 00000000", ins); end
    if (e !== 2'd2) begin fails++; $display("FAIL unmapped_err: got %0d want 2", e); end
    send_str("00FFFFFFFF");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks++;
    if (e !== 2'd2) begin fails++; $display("FAIL type00_err: got %0d want 2", e); end
    send_str("xxFFFFFFFF");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (ins !== 32'h0) begin fails++; $display("FAIL bubble_instr: got %08h want 00000000", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL bubble_err: got %0d want 0", e); end
  endtask

  task automatic test_bad_hex;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("0800G1xyz!");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 3;
    if (v !== 1'b1) begin fails++; $display("FAIL badhex_valid: got %0b want 1", v); end
    if (e !== 2'd1) begin fails++; $display("FAIL badhex_err: got %0d want 1", e); end
    if (ins !== 32'h0) begin fails++; $display("FAIL badhex_instr: got %08h want 00000000", ins); end
    send_str("0F00000010");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (ins !== 32'h08000010) begin fails++; $display("FAIL jmp_after_flush: got %08h want 08000010", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL jmp_err: got %0d want 0", e); end
    send_str("0100");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (v !== 1'b1) begin fails++; $display("FAIL early_cr_valid: got %0b want 1", v); end
    if (e !== 2'd1) begin fails++; $display("FAIL early_cr_err: got %0d want 1", e); end
  endtask

  task automatic test_back_to_back;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("0300000000");
    send_char(8'h0D);
    in_valid = 1'b1;
    in_char  = 8'h30;
    repeat (5) begin
      checks += 3;
      if (out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid: got %0b want 1", out_valid); end
      if (out_instr !== 32'h00000024) begin fails++; $display("FAIL hold_instr: got %08h want 00000024", out_instr); end
      if (in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready: got %0b want 0", in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop_result(v, ins, e);
    checks++;
    if (ins !== 32'h00000024) begin fails++; $display("FAIL hold_final: got %08h want 00000024", ins); end
    send_str("01000000001");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 3;
    if (v !== 1'b1) begin fails++; $display("FAIL long_valid: got %0b want 1", v); end
    if (e !== 2'd3) begin fails++; $display("FAIL long_err: got %0d want 3", e); end
    if (ins !== 32'h0) begin fails++; $display("FAIL long_instr: got %08h want 00000000", ins); end
  endtask

  task automatic test_reset_mid;
    logic v; logic [31:0] ins; logic [1:0] e;
    send_str("0200000");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send_char(8'h0D);
    checks++;
    if (out_valid !== 1'b1 || out_err !== 2'd1) begin
      fails++; $display("FAIL reset_mid_drop: valid=%0b err=%0d want valid=1 err=1", out_valid, out_err);
    end
    pop_result(v, ins, e);
    repeat (3) begin
      checks++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_mid_quiet: got %0b want 0", out_valid); end
      @(negedge clk);
    end
    send_str("0200430800");
    send_char(8'h0D);
    pop_result(v, ins, e);
    checks += 2;
    if (ins !== 32'h00430822) begin fails++; $display("FAIL sub_after_reset: got %08h want 00430822", ins); end
    if (e !== 2'd0) begin fails++; $display("FAIL sub_err: got %0d want 0", e); end
    send_str("0400000000");
    send_char(8'h0D);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_emit_valid: got %0b want 0", out_valid); end
    if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_emit_instr: got %08h want 00000000", out_instr); end
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_emit_ready: got %0b want 1", in_ready); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_rtype;
    test_itype;
    test_unmapped_bubble;
    test_bad_hex;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
